modified_complex_mult: RTL and testbench



---
 rtl/modified_complex_mult_pkg.sv | 16 +
 rtl/modified_complex_mult_if.sv | 37 +++
 rtl/modified_complex_mult_nrs_const_mult.sv | 37 +++
 rtl/modified_complex_mult.sv | 97 +++++++++
 tb/tb_modified_complex_mult.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/modified_complex_mult_pkg.sv
// ---------------------------------------------------------------------------
// modified_complex_mult_pkg
// Shared constants for the NRS complex multiplier slice: sample width,
// NRS coefficient magnitude (0.70703 in Q5.11), full-precision product
// width, output scaling shift and result-buffer geometry.
// ---------------------------------------------------------------------------
package modified_complex_mult_pkg;

  localparam int WIDTH_R_I   = 16;
  localparam logic signed [15:0] NRS_MAG = 16'sh05A8;
  localparam int FULL_W      = 2 * WIDTH_R_I + 1;
  localparam int SCALE_SHIFT = 17;
  localparam int BUF_DEPTH   = 4;
  localparam int ADDR_W      = $clog2(BUF_DEPTH);

endpackage : modified_complex_mult_pkg

// File: rtl/modified_complex_mult_if.sv
// ---------------------------------------------------------------------------
// modified_complex_mult_if
// Bundles the data/control bus of the NRS complex multiplier.
//   en               : enable (write product, read buffer)
//   wr_addr, rd_addr : buffer write / read entry
//   rx_r, rx_i       : received sample, signed
//   nrs_r, nrs_i     : NRS sign bits (1 = negative coefficient)
//   real_part, imag_part : registered scaled product, signed
// master drives the inputs and observes results; slave is the multiplier.
// ---------------------------------------------------------------------------
interface modified_complex_mult_if
  import modified_complex_mult_pkg::*;
#(
  parameter int WIDTH_R_I = modified_complex_mult_pkg::WIDTH_R_I
);

  logic                        en;
  logic [ADDR_W-1:0]           wr_addr;
  logic [ADDR_W-1:0]           rd_addr;
  logic signed [WIDTH_R_I-1:0] rx_r;
  logic signed [WIDTH_R_I-1:0] rx_i;
  logic                        nrs_r;
  logic                        nrs_i;
  logic signed [WIDTH_R_I-1:0] real_part;
  logic signed [WIDTH_R_I-1:0] imag_part;

  modport master (
    output en, wr_addr, rd_addr, rx_r, rx_i, nrs_r, nrs_i,
    input  real_part, imag_part
  );

  modport slave (
    input  en, wr_addr, rd_addr, rx_r, rx_i, nrs_r, nrs_i,
    output real_part, imag_part
  );

endinterface : modified_complex_mult_if

// File: rtl/modified_complex_mult_nrs_const_mult.sv
// ---------------------------------------------------------------------------
// nrs_const_mult
// Combinational signed sample times +/-NRS_MAG, sign chosen by one bit.
//   sample : signed input sample (WIDTH_R_I bits)
//   neg    : 1 selects -NRS_MAG, 0 selects +NRS_MAG
//   prod   : signed product (2*WIDTH_R_I bits, cannot overflow)
// ---------------------------------------------------------------------------
module nrs_const_mult
  import modified_complex_mult_pkg::*;
#(
  parameter int WIDTH_R_I = modified_complex_mult_pkg::WIDTH_R_I
) (
  input  logic signed [WIDTH_R_I-1:0]   sample,
  input  logic                          neg,
  output logic signed [2*WIDTH_R_I-1:0] prod
);

  localparam int PW = 2 * WIDTH_R_I;

  logic signed [PW-1:0] sample_ext_s;
  logic signed [PW-1:0] coef_ext_s;
  logic signed [PW-1:0] mag_s;

  // Sign-extend both operands to the product width so the multiply is
  // evaluated at full precision, then apply the NRS sign.
  always_comb begin
    sample_ext_s = PW'(sample);
    coef_ext_s   = PW'(NRS_MAG);
    mag_s        = sample_ext_s * coef_ext_s;
    if (neg) begin
      prod = -mag_s;
    end else begin
      prod = mag_s;
    end
  end

endmodule : nrs_const_mult

// File: rtl/modified_complex_mult.sv
// ---------------------------------------------------------------------------
// modified_complex_mult
// Multiplies a received complex sample by a QPSK NRS value (+/-0.7071
// +/- j0.7071), scales the product by >>>17 (truncation toward -inf) and
// stores it in a 4-entry result buffer. A registered read port presents
// the entry addressed by rd_addr as held before the current edge.
//   clk : rising-edge clock
//   rst : synchronous active-high reset (clears buffer and outputs)
//   bus : slave side of modified_complex_mult_if (see interface header)
// Latency: inputs captured at edge N appear on the outputs after edge N+1.
// ---------------------------------------------------------------------------
module modified_complex_mult
  import modified_complex_mult_pkg::*;
#(
  parameter int WIDTH_R_I = modified_complex_mult_pkg::WIDTH_R_I
) (
  input  logic                   clk,
  input  logic                   rst,
  modified_complex_mult_if.slave bus
);

  localparam int PW = 2 * WIDTH_R_I;
  localparam int FW = 2 * WIDTH_R_I + 1;

  logic signed [PW-1:0] prod_rr_s;  // rx_r * c_r
  logic signed [PW-1:0] prod_ii_s;  // rx_i * c_i
  logic signed [PW-1:0] prod_ri_s;  // rx_r * c_i
  logic signed [PW-1:0] prod_ir_s;  // rx_i * c_r

  logic signed [FW-1:0]        full_r_s;
  logic signed [FW-1:0]        full_i_s;
  logic signed [WIDTH_R_I-1:0] res_r_s;
  logic signed [WIDTH_R_I-1:0] res_i_s;

  logic signed [WIDTH_R_I-1:0] buf_re_r [BUF_DEPTH];
  logic signed [WIDTH_R_I-1:0] buf_im_r [BUF_DEPTH];
  logic signed [WIDTH_R_I-1:0] real_part_r;
  logic signed [WIDTH_R_I-1:0] imag_part_r;

  nrs_const_mult #(.WIDTH_R_I(WIDTH_R_I)) u_mult_rr (
    .sample (bus.rx_r),
    .neg    (bus.nrs_r),
    .prod   (prod_rr_s)
  );

  nrs_const_mult #(.WIDTH_R_I(WIDTH_R_I)) u_mult_ii (
    .sample (bus.rx_i),
    .neg    (bus.nrs_i),
    .prod   (prod_ii_s)
  );

  nrs_const_mult #(.WIDTH_R_I(WIDTH_R_I)) u_mult_ri (
    .sample (bus.rx_r),
    .neg    (bus.nrs_i),
    .prod   (prod_ri_s)
  );

  nrs_const_mult #(.WIDTH_R_I(WIDTH_R_I)) u_mult_ir (
    .sample (bus.rx_i),
    .neg    (bus.nrs_r),
    .prod   (prod_ir_s)
  );

  // Combine partial products at one extra bit of headroom, then keep the
  // bits above the scaling shift; arithmetic shift floors toward -inf.
  always_comb begin
    full_r_s = FW'(prod_rr_s) - FW'(prod_ii_s);
    full_i_s = FW'(prod_ri_s) + FW'(prod_ir_s);
    res_r_s  = WIDTH_R_I'(full_r_s >>> SCALE_SHIFT);
    res_i_s  = WIDTH_R_I'(full_i_s >>> SCALE_SHIFT);
  end

  // Result buffer and registered read port; the read sees the entry as it
  // was before this edge, so a same-address write shows up one edge later.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_re_r[i] <= '0;
        buf_im_r[i] <= '0;
      end
      real_part_r <= '0;
      imag_part_r <= '0;
    end else if (bus.en) begin
      buf_re_r[bus.wr_addr] <= res_r_s;
      buf_im_r[bus.wr_addr] <= res_i_s;
      real_part_r           <= buf_re_r[bus.rd_addr];
      imag_part_r           <= buf_im_r[bus.rd_addr];
    end else begin
      real_part_r <= '0;
      imag_part_r <= '0;
    end
  end

  assign bus.real_part = real_part_r;
  assign bus.imag_part = imag_part_r;

endmodule : modified_complex_mult

// File: tb/tb_modified_complex_mult.sv
// ---------------------------------------------------------------------------
// tb_modified_complex_mult
// Self-checking bench: directed vector table, addressing / enable / reset
// sequences and a random sweep against an integer reference model.
// ---------------------------------------------------------------------------
module tb_modified_complex_mult;

  localparam int W = 16;

  logic clk;
  logic rst;

  modified_complex_mult_if #(.WIDTH_R_I(W)) bus ();

  modified_complex_mult #(.WIDTH_R_I(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic signed [W-1:0] rx_r;
    logic signed [W-1:0] rx_i;
    logic                nr;
    logic                ni;
    logic signed [W-1:0] er;
    logic signed [W-1:0] ei;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  int n_checks;
  int n_fail;

  logic signed [W-1:0] mdl_re [4];
  logic signed [W-1:0] mdl_im [4];

  // Reference: integer arithmetic on 64-bit values, floor via >>>
  function automatic logic [2*W-1:0] ref_prod(input logic signed [W-1:0] xr,
                                              input logic signed [W-1:0] xi,
                                              input logic nr, input logic ni);
    longint cr, ci, fr, fi, sr, si;
    cr = nr ? -64'sd1448 : 64'sd1448;
    ci = ni ? -64'sd1448 : 64'sd1448;
    fr = longint'(xr) * cr - longint'(xi) * ci;
    fi = longint'(xr) * ci + longint'(xi) * cr;
    sr = fr >>> 17;
    si = fi >>> 17;
    return {sr[W-1:0], si[W-1:0]};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [1:0] wa, input logic [1:0] ra,
                       input logic signed [W-1:0] xr, input logic signed [W-1:0] xi,
                       input logic nr, input logic ni);
    bus.en      = en;
    bus.wr_addr = wa;
    bus.rd_addr = ra;
    bus.rx_r    = xr;
    bus.rx_i    = xi;
    bus.nrs_r   = nr;
    bus.nrs_i   = ni;
  endtask

  initial begin
    logic [2*W-1:0] p;
    logic [1:0]     order [4];
    logic signed [W-1:0] er, ei;
    logic           en_v, rst_v;
    logic [1:0]     wa, ra;
    logic signed [W-1:0] xr, xi;
    logic           nr, ni;

    n_checks = 0;
    n_fail   = 0;

    vecs[0]  = '{16'sd16384,  16'sd0,      1'b0, 1'b0,  16'sd181,  16'sd181};
    vecs[1]  = '{16'sd16384,  16'sd0,      1'b1, 1'b0, -16'sd181,  16'sd181};
    vecs[2]  = '{16'sd16384,  16'sd0,      1'b1, 1'b1, -16'sd181, -16'sd181};
    vecs[3]  = '{16'sd16384,  16'sd0,      1'b0, 1'b1,  16'sd181, -16'sd181};
    vecs[4]  = '{16'sd0,      16'sd16384,  1'b0, 1'b0, -16'sd181,  16'sd181};
    vecs[5]  = '{16'sd0,      16'sd16384,  1'b0, 1'b1,  16'sd181,  16'sd181};
    vecs[6]  = '{16'sd1,      16'sd0,      1'b0, 1'b0,  16'sd0,    16'sd0};
    vecs[7]  = '{-16'sd1,     16'sd0,      1'b0, 1'b0, -16'sd1,   -16'sd1};
    vecs[8]  = '{-16'sd32768, -16'sd32768, 1'b0, 1'b0,  16'sd0,   -16'sd724};
    vecs[9]  = '{16'sd32767,  -16'sd32768, 1'b0, 1'b1, -16'sd1,   -16'sd724};
    vecs[10] = '{16'sd100,    -16'sd200,   1'b0, 1'b0,  16'sd3,   -16'sd2};

    // Reset held for 3 edges with random inputs
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'($urandom), 2'($urandom), 16'($urandom), 16'($urandom),
            1'($urandom), 1'($urandom));
      cyc();
      check("reset_real", bus.real_part, 16'h0000);
      check("reset_imag", bus.imag_part, 16'h0000);
    end
    rst = 1'b0;

    // Every entry reads 0 after release (same-address write is not yet visible)
    for (int a = 0; a < 4; a++) begin
      drive(1'b1, 2'(a), 2'(a), 16'sd0, 16'sd0, 1'b0, 1'b0);
      cyc();
      check("post_reset_real", bus.real_part, 16'h0000);
      check("post_reset_imag", bus.imag_part, 16'h0000);
    end

    // Directed vector table: write addr 0, then read it back while writing addr 1
    for (int v = 0; v < NV; v++) begin
      drive(1'b1, 2'd0, 2'd1, vecs[v].rx_r, vecs[v].rx_i, vecs[v].nr, vecs[v].ni);
      cyc();
      drive(1'b1, 2'd1, 2'd0, vecs[v].rx_r, vecs[v].rx_i, vecs[v].nr, vecs[v].ni);
      cyc();
      check($sformatf("vec%0d_real", v), bus.real_part, vecs[v].er);
      check($sformatf("vec%0d_imag", v), bus.imag_part, vecs[v].ei);
    end

    // Addressing: four samples into addrs 0..3 (vectors 0,4,8,10)
    drive(1'b1, 2'd0, 2'd0, vecs[0].rx_r,  vecs[0].rx_i,  vecs[0].nr,  vecs[0].ni);  cyc();
    drive(1'b1, 2'd1, 2'd0, vecs[4].rx_r,  vecs[4].rx_i,  vecs[4].nr,  vecs[4].ni);  cyc();
    drive(1'b1, 2'd2, 2'd0, vecs[8].rx_r,  vecs[8].rx_i,  vecs[8].nr,  vecs[8].ni);  cyc();
    drive(1'b1, 2'd3, 2'd0, vecs[10].rx_r, vecs[10].rx_i, vecs[10].nr, vecs[10].ni); cyc();
    mdl_re[0] = vecs[0].er;  mdl_im[0] = vecs[0].ei;
    mdl_re[1] = vecs[4].er;  mdl_im[1] = vecs[4].ei;
    mdl_re[2] = vecs[8].er;  mdl_im[2] = vecs[8].ei;
    mdl_re[3] = vecs[10].er; mdl_im[3] = vecs[10].ei;
    order[0] = 2'd3; order[1] = 2'd0; order[2] = 2'd2; order[3] = 2'd1;
    for (int k = 0; k < 4; k++) begin
      // Write is disabled through en toggling would zero outputs, so rewrite
      // an untouched scratch value into the entry being read: the read sees
      // the old value, and afterwards restore the model accordingly.
      drive(1'b1, order[k], order[k], 16'sd0, 16'sd0, 1'b0, 1'b0);
      cyc();
      check($sformatf("addr%0d_real", order[k]), bus.real_part, mdl_re[order[k]]);
      check($sformatf("addr%0d_imag", order[k]), bus.imag_part, mdl_im[order[k]]);
      mdl_re[order[k]] = 16'sd0;
      mdl_im[order[k]] = 16'sd0;
    end

    // Same-edge read/write: old contents first, new value one edge later
    drive(1'b1, 2'd2, 2'd2, vecs[0].rx_r, vecs[0].rx_i, vecs[0].nr, vecs[0].ni);
    cyc();
    check("same_addr_old_real", bus.real_part, 16'h0000);
    check("same_addr_old_imag", bus.imag_part, 16'h0000);
    drive(1'b1, 2'd3, 2'd2, 16'sd0, 16'sd0, 1'b0, 1'b0);
    cyc();
    check("same_addr_new_real", bus.real_part, 16'sd181);
    check("same_addr_new_imag", bus.imag_part, 16'sd181);
    mdl_re[2] = 16'sd181; mdl_im[2] = 16'sd181;

    // Enable low: outputs 0 and no write even with a live product on addr 2
    drive(1'b0, 2'd2, 2'd2, vecs[2].rx_r, vecs[2].rx_i, vecs[2].nr, vecs[2].ni);
    cyc();
    check("en_low_real", bus.real_part, 16'h0000);
    check("en_low_imag", bus.imag_part, 16'h0000);
    drive(1'b1, 2'd0, 2'd2, 16'sd0, 16'sd0, 1'b0, 1'b0);
    cyc();
    check("en_back_real", bus.real_part, 16'sd181);
    check("en_back_imag", bus.imag_part, 16'sd181);

    // Random sweep with occasional enable drop and mid-stream reset
    for (int a = 0; a < 4; a++) begin
      drive(1'b1, 2'(a), 2'(a), 16'sd0, 16'sd0, 1'b0, 1'b0);
      cyc();
      mdl_re[a] = 16'sd0;
      mdl_im[a] = 16'sd0;
    end
    for (int t = 0; t < 400; t++) begin
      rst_v = ($urandom_range(0, 39) == 0);
      en_v  = ($urandom_range(0, 7) != 0);
      wa    = 2'($urandom);
      ra    = 2'($urandom);
      xr    = 16'($urandom);
      xi    = 16'($urandom);
      if (t % 16 == 0) xr = -16'sd32768;
      if (t % 16 == 1) xi = 16'sd32767;
      nr    = 1'($urandom);
      ni    = 1'($urandom);
      rst   = rst_v;
      drive(en_v, wa, ra, xr, xi, nr, ni);
      if (rst_v) begin
        er = 16'sd0;
        ei = 16'sd0;
      end else if (en_v) begin
        er = mdl_re[ra];
        ei = mdl_im[ra];
      end else begin
        er = 16'sd0;
        ei = 16'sd0;
      end
      cyc();
      check("sweep_real", bus.real_part, er);
      check("sweep_imag", bus.imag_part, ei);
      if (rst_v) begin
        for (int a = 0; a < 4; a++) begin
          mdl_re[a] = 16'sd0;
          mdl_im[a] = 16'sd0;
        end
      end else if (en_v) begin
        p = ref_prod(xr, xi, nr, ni);
        mdl_re[wa] = p[2*W-1:W];
        mdl_im[wa] = p[W-1:0];
      end
    end
    rst = 1'b0;

    // Drain: read back every entry without disturbing it
    for (int a = 0; a < 4; a++) begin
      drive(1'b1, 2'(a), 2'(a), 16'sd0, 16'sd0, 1'b0, 1'b0);
      cyc();
      check("drain_real", bus.real_part, mdl_re[a]);
      check("drain_imag", bus.imag_part, mdl_im[a]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_modified_complex_mult
